// File: rtl/mul2_seq_composer.sv
// Iterative WIDTH x WIDTH unsigned multiplier that drives an external 2x2 core, one digit product per clock.
// Optional golden self-check (out_err, err_count) is enabled by defining MUL2_SEQ_GOLDEN_CHECK_EN.
module mul2_seq_composer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [1:0]           core_a,
    output logic [1:0]           core_b,
    input  logic [3:0]           core_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
    output logic                 out_err,
    output logic [15:0]          err_count,
`endif
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid/data from this block stay stable until that edge.

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  reg_a, reg_b;
    logic [PW-1:0]     acc, p_ext, acc_sum;
    logic [CW-1:0]     i, j;
    logic [CW:0]       shift;
    logic              last;

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_a    = 2'b00;
        core_b    = 2'b00;
        p_ext     = '0;
        p_ext[3:0] = core_p;
        // Digit weight is 4^(i+j), i.e. a left shift by 2*(i+j) bits.
        shift     = {1'b0, i} + {1'b0, j};
        acc_sum   = acc + (p_ext << {shift, 1'b0});
        last      = (i == LAST) && (j == LAST);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                core_a = reg_a[{i, 1'b0} +: 2];
                core_b = reg_b[{j, 1'b0} +: 2];
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            reg_a <= '0;
            reg_b <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            out_p <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        reg_a <= in_a;
                        reg_b <= in_b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (last) out_p <= acc_sum;
                end
                default: ;
            endcase
        end
    end

`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
    logic [PW-1:0] golden;

    assign golden  = {{WIDTH{1'b0}}, reg_a} * {{WIDTH{1'b0}}, reg_b};
    assign out_err = (state == DONE) && (out_p != golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if ((state == DONE) && out_ready && out_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul2_seq_composer.sv
// Bench for mul2_seq_composer: WIDTH=4 and WIDTH=8 instances, each fed by a behavioural 2x2 core model.
module tb_mul2_seq_composer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] in_a4, in_b4, core_p4;
    logic [1:0] core_a4, core_b4, dbg4;
    logic [7:0] out_p4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic [3:0]  core_p8;
    logic [1:0]  core_a8, core_b8, dbg8;
    logic [15:0] out_p8;

`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
    logic        out_err4, out_err8;
    logic [15:0] err_count4, err_count8;
`endif

    bit fault4 = 1'b0;
    assign core_p4 = (fault4 && core_a4 == 2'd1 && core_b4 == 2'd1) ? 4'd4
                                                                    : {2'b00, core_a4} * {2'b00, core_b4};
    assign core_p8 = {2'b00, core_a8} * {2'b00, core_b8};

    mul2_seq_composer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .core_a(core_a4), .core_b(core_b4), .core_p(core_p4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_p(out_p4),
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        .out_err(out_err4), .err_count(err_count4),
`endif
        .dbg_state(dbg4)
    );

    mul2_seq_composer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .core_a(core_a8), .core_b(core_b8), .core_p(core_p8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_p(out_p8),
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        .out_err(out_err8), .err_count(err_count8),
`endif
        .dbg_state(dbg8)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];
    bit          err_q[$];
    int          exp_err_cnt = 0;

    // Reference: sum of digit products weighted by 4^(i+j), using the bench's core model.
    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b,
                                              input int n, input bit fault);
        int s = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                int da = (int'(a) >> (2 * i)) & 3;
                int db = (int'(b) >> (2 * j)) & 3;
                int p  = (fault && da == 1 && db == 1) ? 4 : da * db;
                s += p << (2 * (i + j));
            end
        end
        return 16'(s & ((1 << (4 * n)) - 1));
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_p4 !== 8'd0) begin
            $display("FAIL reset4 ready=%b valid=%b p=%0d want 1 0 0", in_ready4, out_valid4, out_p4);
        end else n_pass++;
        n_checks++;
        if (core_a4 !== 2'd0 || core_b4 !== 2'd0) begin
            $display("FAIL reset4_core a=%0d b=%0d want 0 0", core_a4, core_b4);
        end else n_pass++;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || out_p8 !== 16'd0) begin
            $display("FAIL reset8 ready=%b valid=%b p=%0d want 1 0 0", in_ready8, out_valid8, out_p8);
        end else n_pass++;
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        n_checks++;
        if (err_count4 !== 16'd0) begin
            $display("FAIL reset_errcnt got=%0d want 0", err_count4);
        end else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            $display("FAIL post_reset4 ready=%b valid=%b want 1 0", in_ready4, out_valid4);
        end else n_pass++;
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input bit rand_bp);
        int lat;
        logic [7:0] held;
        logic [15:0] expv;
        bit errv;
        bit done;
        expv = model_mul({4'h0, a}, {4'h0, b}, 2, fault4);
        exp_q.push_back(expv);
        err_q.push_back(int'(expv) != int'(a) * int'(b));
        n_checks++;
        if (in_ready4 !== 1'b1) begin
            $display("FAIL accept_ready4 got=%b want 1", in_ready4);
        end else n_pass++;
        in_a4 = a;
        in_b4 = b;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_a4 = 4'($urandom);
        in_b4 = 4'($urandom);
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 40) begin
            n_checks++;
            if (in_ready4 !== 1'b0) begin
                $display("FAIL busy_ready4 a=%0d b=%0d got=%b want 0", a, b, in_ready4);
            end else n_pass++;
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            $display("FAIL latency4 a=%0d b=%0d got=%0d want 4", a, b, lat);
        end else n_pass++;
        expv = exp_q.pop_front();
        errv = err_q.pop_front();
        n_checks++;
        if (out_p4 !== expv[7:0]) begin
            $display("FAIL product4 a=%0d b=%0d got=%0d want %0d", a, b, out_p4, expv[7:0]);
        end else n_pass++;
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        n_checks++;
        if (out_err4 !== errv) begin
            $display("FAIL out_err4 a=%0d b=%0d got=%b want %b", a, b, out_err4, errv);
        end else n_pass++;
`endif
        held = out_p4;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            out_ready4 = (rand_bp && k < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            if (out_ready4) begin
                done = 1'b1;
            end else begin
                n_checks++;
                if (out_valid4 !== 1'b1 || out_p4 !== held || in_ready4 !== 1'b0) begin
                    $display("FAIL stall4 valid=%b p=%0d ready=%b want 1 %0d 0",
                             out_valid4, out_p4, in_ready4, held);
                end else n_pass++;
            end
        end
        out_ready4 = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            $display("FAIL release4 valid=%b ready=%b want 0 1", out_valid4, in_ready4);
        end else n_pass++;
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        if (errv) exp_err_cnt++;
        n_checks++;
        if (err_count4 !== 16'(exp_err_cnt)) begin
            $display("FAIL err_count4 got=%0d want %0d", err_count4, exp_err_cnt);
        end else n_pass++;
`endif
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [15:0] expv;
        expv = model_mul(a, b, 4, 1'b0);
        in_a8 = a;
        in_b8 = b;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_a8 = 8'($urandom);
        in_b8 = 8'($urandom);
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 60) begin
            if (lat < 16) begin
                n_checks++;
                if (core_a8 !== a[2 * (lat / 4) +: 2] || core_b8 !== b[2 * (lat % 4) +: 2]) begin
                    $display("FAIL digits8 step=%0d got=%0d,%0d want %0d,%0d", lat, core_a8, core_b8,
                             a[2 * (lat / 4) +: 2], b[2 * (lat % 4) +: 2]);
                end else n_pass++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != 16) begin
            $display("FAIL latency8 a=%0d b=%0d got=%0d want 16", a, b, lat);
        end else n_pass++;
        n_checks++;
        if (out_p8 !== expv) begin
            $display("FAIL product8 a=%0d b=%0d got=%0d want %0d", a, b, out_p8, expv);
        end else n_pass++;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || core_a8 !== 2'd0) begin
            $display("FAIL release8 valid=%b ready=%b core_a=%0d want 0 1 0", out_valid8, in_ready8, core_a8);
        end else n_pass++;
    endtask

    task automatic test_max_operands();
        do_op4(4'd15, 4'd15, 1'b0);
    endtask

    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op4(4'(a), 4'(b), 1'b1);
            end
        end
    endtask

    task automatic test_width8();
        do_op8(8'hAB, 8'h00);
        do_op8(8'hFF, 8'hFF);
        for (int k = 0; k < 6; k++) do_op8(8'($urandom), 8'($urandom));
    endtask

    task automatic test_rst_mid_mul();
        bit seen;
        in_a4 = 4'd9;
        in_b4 = 4'd6;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err_cnt = 0;
        #2;
        n_checks++;
        if (out_p4 !== 8'd0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            $display("FAIL rst_mid p=%0d valid=%b ready=%b want 0 0 1", out_p4, out_valid4, in_ready4);
        end else n_pass++;
        n_checks++;
        if (core_a4 !== 2'd0 || core_b4 !== 2'd0) begin
            $display("FAIL rst_mid_core a=%0d b=%0d want 0 0", core_a4, core_b4);
        end else n_pass++;
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid4 === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen || in_ready4 !== 1'b1) begin
            $display("FAIL rst_discard valid_seen=%b ready=%b want 0 1", seen, in_ready4);
        end else n_pass++;
        do_op4(4'd2, 4'd3, 1'b0);
    endtask

`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
    task automatic test_golden_check();
        fault4 = 1'b1;
        do_op4(4'd5, 4'd5, 1'b0);
        do_op4(4'd2, 4'd2, 1'b0);
        fault4 = 1'b0;
    endtask
`endif

    initial begin
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b0;
        test_reset();
        test_max_operands();
        test_exhaustive();
        test_width8();
        test_rst_mid_mul();
`ifdef MUL2_SEQ_GOLDEN_CHECK_EN
        test_golden_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
